// File: rtl/vec_alu_seq_pkg.sv
// Shared constants, ALU control encodings and sequencer state type
// for the vector element sequencer.
package vec_alu_seq_pkg;

  localparam int DW_DEF       = 32;
  localparam int VLEN_MAX_DEF = 32;
  localparam int CW_DEF       = 5;

  typedef enum logic [5:0] {
    FN_NOP  = 6'h00,
    FN_SLL  = 6'h04,
    FN_SRL  = 6'h06,
    FN_MULT = 6'h18,
    FN_ADD  = 6'h20,
    FN_SUB  = 6'h22,
    FN_LW   = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_SLT  = 6'h2A,
    FN_SW   = 6'h2B,
    FN_ABS  = 6'h30
  } funct_e;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_IMM   = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/vec_alu_pipe_reg.sv
// Valid+data pipeline register that holds its contents while stalled.
module vec_alu_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  // Data only moves with a valid element so outputs keep the last element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/vec_alu_seq.sv
// Element sequencer: steps a vector instruction through a shared scalar ALU
// with a three-stage read / operate / writeback pipeline.
module vec_alu_seq
  import vec_alu_seq_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int VLEN_MAX = VLEN_MAX_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          in_funct,
  input  logic [1:0]          in_aluop,
  input  logic                in_alusrc,
  input  logic [4:0]          in_shamt,
  input  logic [DW-1:0]       in_immd,
  input  logic [CW:0]         in_vlen,
  input  logic                stall,
  output logic [CW-1:0]       rd_idx,
  input  logic [DW-1:0]       rd_data1,
  input  logic [DW-1:0]       rd_data2,
  output logic [CW-1:0]       alu_cnt,
  output logic [5:0]          alu_funct,
  output logic [1:0]          alu_op,
  output logic                alu_src,
  output logic [4:0]          alu_shamt,
  output logic [DW-1:0]       alu_immd,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  input  logic [DW-1:0]       alu_result,
  input  logic                alu_overflow,
  output logic                wb_en,
  output logic [CW-1:0]       wb_idx,
  output logic [DW-1:0]       wb_data,
  output logic [VLEN_MAX-1:0] ovf_mask,
  output logic                done
);

  localparam logic [CW:0] VMAX = (CW+1)'(VLEN_MAX);
  localparam logic [CW:0] ONE  = (CW+1)'(1);

  state_e          state, state_nxt;
  logic [CW-1:0]   counter, counter_nxt;
  logic [CW:0]     vlen_q;
  logic [CW:0]     vlen_clamped;
  logic            accept, issue, wb_fire, last_issue, last_wb;
  logic            s1_valid, s2_valid, s2_ovf;
  logic [2*DW+CW-1:0] s1_data;
  logic [DW+CW:0]     s2_data;

  assign in_ready     = (state == ST_IDLE) && !stall;
  assign accept       = in_valid && in_ready;
  assign issue        = (state == ST_RUN) && !stall;
  assign wb_fire      = s2_valid && !stall;
  assign vlen_clamped = (in_vlen > VMAX) ? VMAX : in_vlen;
  assign last_issue   = ({1'b0, counter} == (vlen_q - ONE));
  assign last_wb      = wb_fire && ({1'b0, wb_idx} == (vlen_q - ONE));
  assign rd_idx       = counter;
  assign wb_en        = wb_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      counter <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    done        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          counter_nxt = '0;
          state_nxt   = (vlen_clamped == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // The counter parks on the last element instead of wrapping.
        if (issue) begin
          if (last_issue) state_nxt = ST_DRAIN;
          else            counter_nxt = counter + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (last_wb) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (!stall) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control fields are captured once per instruction and held throughout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_funct <= '0;
      alu_op    <= '0;
      alu_src   <= 1'b0;
      alu_shamt <= '0;
      alu_immd  <= '0;
      vlen_q    <= '0;
      ovf_mask  <= '0;
    end else if (accept) begin
      alu_funct <= in_funct;
      alu_op    <= in_aluop;
      alu_src   <= in_alusrc;
      alu_shamt <= in_shamt;
      alu_immd  <= in_immd;
      vlen_q    <= vlen_clamped;
      ovf_mask  <= '0;
    end else if (wb_fire) begin
      ovf_mask[wb_idx] <= ovf_mask[wb_idx] | s2_ovf;
    end
  end

  vec_alu_pipe_reg #(.W(2*DW+CW)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .in_valid  (issue),
    .in_data   ({rd_data1, rd_data2, counter}),
    .out_valid (s1_valid),
    .out_data  (s1_data)
  );

  assign {alu_a, alu_b, alu_cnt} = s1_data;

  vec_alu_pipe_reg #(.W(DW+CW+1)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .in_valid  (s1_valid),
    .in_data   ({alu_result, alu_cnt, alu_overflow}),
    .out_valid (s2_valid),
    .out_data  (s2_data)
  );

  assign {wb_data, wb_idx, s2_ovf} = s2_data;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Directed bench for vec_alu_seq with a behavioural register file and adder ALU.
module tb_vec_alu_seq;
  import vec_alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [1:0]  in_aluop;
  logic        in_alusrc;
  logic [4:0]  in_shamt;
  logic [31:0] in_immd;
  logic [5:0]  in_vlen;
  logic        stall;
  logic [4:0]  rd_idx;
  logic [31:0] rd_data1, rd_data2;
  logic [4:0]  alu_cnt;
  logic [5:0]  alu_funct;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_immd, alu_a, alu_b, alu_result;
  logic        alu_overflow;
  logic        wb_en;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic [31:0] ovf_mask;
  logic        done;

  logic [31:0] rf1 [32];
  logic [31:0] rf2 [32];
  logic [31:0] opb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rd_data1     = rf1[rd_idx];
  assign rd_data2     = rf2[rd_idx];
  assign opb          = alu_src ? alu_immd : alu_b;
  assign alu_result   = alu_a + opb;
  assign alu_overflow = (alu_a[31] == opb[31]) && (alu_result[31] != alu_a[31]);

  vec_alu_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_aluop(in_aluop), .in_alusrc(in_alusrc),
    .in_shamt(in_shamt), .in_immd(in_immd), .in_vlen(in_vlen), .stall(stall),
    .rd_idx(rd_idx), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .alu_cnt(alu_cnt), .alu_funct(alu_funct), .alu_op(alu_op), .alu_src(alu_src),
    .alu_shamt(alu_shamt), .alu_immd(alu_immd), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .wb_en(wb_en),
    .wb_idx(wb_idx), .wb_data(wb_data), .ovf_mask(ovf_mask), .done(done)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offers one ADD instruction; returns at the first cycle after acceptance.
  task automatic applyStimulus(input logic [5:0] vlen);
    in_valid  = 1'b1;
    in_funct  = FN_ADD;
    in_aluop  = ALUOP_RTYPE;
    in_alusrc = 1'b0;
    in_shamt  = 5'd3;
    in_immd   = 32'h0000_1234;
    in_vlen   = vlen;
    @(negedge clk);
    in_valid  = 1'b0;
    in_funct  = FN_SUB;
    in_vlen   = 6'd7;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wb_count;
    bit done_seen;

    rst = 1'b1; in_valid = 1'b0; stall = 1'b0;
    in_funct = '0; in_aluop = '0; in_alusrc = 1'b0; in_shamt = '0;
    in_immd = '0; in_vlen = '0;
    for (int i = 0; i < 32; i++) begin rf1[i] = i; rf2[i] = 32'd10; end
    step(2);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_wb_en", wb_en, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ovf_mask", ovf_mask, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    rst = 1'b0;
    step(1);

    // Basic four-element ADD
    applyStimulus(6'd4);
    checkOutput("t1_rd_idx0", rd_idx, 0);
    checkOutput("t1_wb_idle", wb_en, 0);
    checkOutput("t1_busy", in_ready, 0);
    checkOutput("t1_funct", alu_funct, FN_ADD);
    step(1);
    checkOutput("t1_fill_wb", wb_en, 0);
    checkOutput("t1_alu_a", alu_a, 0);
    checkOutput("t1_alu_b", alu_b, 10);
    for (int i = 0; i < 4; i++) begin
      step(1);
      checkOutput($sformatf("t1_wb_en%0d", i), wb_en, 1);
      checkOutput($sformatf("t1_wb_idx%0d", i), wb_idx, i);
      checkOutput($sformatf("t1_wb_data%0d", i), wb_data, 32'd10 + i);
      checkOutput($sformatf("t1_done_early%0d", i), done, 0);
    end
    step(1);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_wb_after", wb_en, 0);
    checkOutput("t1_ovf", ovf_mask, 0);
    step(1);
    checkOutput("t1_done_pulse", done, 0);
    checkOutput("t1_ready_back", in_ready, 1);

    // Signed overflow on element 1
    rf1[0] = 32'd5; rf2[0] = 32'd6;
    rf1[1] = 32'h7FFF_FFFF; rf2[1] = 32'd1;
    applyStimulus(6'd2);
    step(2);
    checkOutput("t2_wb0", wb_data, 32'd11);
    step(1);
    checkOutput("t2_wb1_idx", wb_idx, 1);
    checkOutput("t2_wb1", wb_data, 32'h8000_0000);
    step(1);
    checkOutput("t2_done", done, 1);
    checkOutput("t2_ovf", ovf_mask, 32'h2);
    step(1);

    // Zero-length vector
    applyStimulus(6'd0);
    checkOutput("t3_done", done, 1);
    checkOutput("t3_wb_en", wb_en, 0);
    checkOutput("t3_ovf_cleared", ovf_mask, 0);
    step(1);
    checkOutput("t3_done_pulse", done, 0);
    checkOutput("t3_ready", in_ready, 1);
    checkOutput("t3_wb_en_after", wb_en, 0);

    // Oversized vector clamps to 32 elements
    for (int i = 0; i < 32; i++) begin rf1[i] = i * 3; rf2[i] = 32'd100; end
    applyStimulus(6'd40);
    wb_count = 0;
    done_seen = 0;
    for (int c = 0; c < 50 && !done_seen; c++) begin
      if (wb_en) begin
        checkOutput($sformatf("t4_idx%0d", wb_count), wb_idx, wb_count);
        checkOutput($sformatf("t4_data%0d", wb_count), wb_data, 32'd100 + 3 * wb_count);
        wb_count++;
      end
      if (done) begin
        done_seen = 1;
        checkOutput("t4_counter_no_wrap", rd_idx, 31);
      end else begin
        step(1);
      end
    end
    checkOutput("t4_done_seen", done_seen, 1);
    checkOutput("t4_wb_count", wb_count, 32);
    step(1);

    // Stall while element 1 sits in writeback, then stall on the done cycle
    for (int i = 0; i < 32; i++) begin rf1[i] = i; rf2[i] = 32'd10; end
    applyStimulus(6'd4);
    step(2);
    checkOutput("t5_wb0", wb_idx, 0);
    step(1);
    stall = 1'b1;
    #1;
    checkOutput("t5_stall_wb0", wb_en, 0);
    checkOutput("t5_stall_ready", in_ready, 0);
    step(1);
    checkOutput("t5_stall_wb1", wb_en, 0);
    checkOutput("t5_stall_hold_idx", wb_idx, 1);
    step(1);
    checkOutput("t5_stall_wb2", wb_en, 0);
    step(1);
    stall = 1'b0;
    #1;
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("t5_wb_en%0d", i), wb_en, 1);
      checkOutput($sformatf("t5_wb_idx%0d", i), wb_idx, i);
      checkOutput($sformatf("t5_wb_data%0d", i), wb_data, 32'd10 + i);
      step(1);
    end
    checkOutput("t5_done", done, 1);
    stall = 1'b1;
    #1;
    checkOutput("t5_done_stalled", done, 0);
    step(1);
    stall = 1'b0;
    #1;
    checkOutput("t5_done_released", done, 1);
    step(1);
    checkOutput("t5_ready", in_ready, 1);

    // Reset in the middle of an eight-element instruction
    applyStimulus(6'd8);
    step(5);
    checkOutput("t6_rd_idx5", rd_idx, 5);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_wb_en", wb_en, 0);
    checkOutput("t6_rst_wb_data", wb_data, 0);
    checkOutput("t6_rst_alu_a", alu_a, 0);
    checkOutput("t6_rst_alu_cnt", alu_cnt, 0);
    checkOutput("t6_rst_funct", alu_funct, 0);
    checkOutput("t6_rst_rd_idx", rd_idx, 0);
    checkOutput("t6_rst_ready", in_ready, 1);
    step(1);
    rst = 1'b0;
    wb_count = 0;
    for (int c = 0; c < 6; c++) begin
      if (wb_en) wb_count++;
      step(1);
    end
    checkOutput("t6_no_wb_after_rst", wb_count, 0);
    checkOutput("t6_ready_after", in_ready, 1);
    applyStimulus(6'd1);
    step(2);
    checkOutput("t6_new_wb_en", wb_en, 1);
    checkOutput("t6_new_wb_data", wb_data, 32'd10);
    step(1);
    checkOutput("t6_new_done", done, 1);
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
